// File: rtl/seg7_pkg.sv
// rtl/seg7_pkg.sv - shared hex glyph set and limits for the seven-segment scan driver
package seg7_pkg;

    localparam int SEG7_MAX_DIGITS = 8;

    // Active-low {a,b,c,d,e,f,g}
    localparam logic [6:0] SEG7_BLANK   = 7'h7F;
    localparam logic [6:0] SEG7_GLYPH_0 = 7'b0000001;
    localparam logic [6:0] SEG7_GLYPH_1 = 7'b1001111;
    localparam logic [6:0] SEG7_GLYPH_2 = 7'b0010010;
    localparam logic [6:0] SEG7_GLYPH_3 = 7'b0000110;
    localparam logic [6:0] SEG7_GLYPH_4 = 7'b1001100;
    localparam logic [6:0] SEG7_GLYPH_5 = 7'b0100100;
    localparam logic [6:0] SEG7_GLYPH_6 = 7'b0100000;
    localparam logic [6:0] SEG7_GLYPH_7 = 7'b0001111;
    localparam logic [6:0] SEG7_GLYPH_8 = 7'b0000000;
    localparam logic [6:0] SEG7_GLYPH_9 = 7'b0000100;
    localparam logic [6:0] SEG7_GLYPH_A = 7'b0001000;
    localparam logic [6:0] SEG7_GLYPH_B = 7'b1100000;
    localparam logic [6:0] SEG7_GLYPH_C = 7'b0110001;
    localparam logic [6:0] SEG7_GLYPH_D = 7'b1000010;
    localparam logic [6:0] SEG7_GLYPH_E = 7'b0110000;
    localparam logic [6:0] SEG7_GLYPH_F = 7'b0111000;

    function automatic logic [6:0] seg7_glyph(input logic [3:0] nibble);
        logic [6:0] g;
        case (nibble)
            4'h0:    g = SEG7_GLYPH_0;
            4'h1:    g = SEG7_GLYPH_1;
            4'h2:    g = SEG7_GLYPH_2;
            4'h3:    g = SEG7_GLYPH_3;
            4'h4:    g = SEG7_GLYPH_4;
            4'h5:    g = SEG7_GLYPH_5;
            4'h6:    g = SEG7_GLYPH_6;
            4'h7:    g = SEG7_GLYPH_7;
            4'h8:    g = SEG7_GLYPH_8;
            4'h9:    g = SEG7_GLYPH_9;
            4'hA:    g = SEG7_GLYPH_A;
            4'hB:    g = SEG7_GLYPH_B;
            4'hC:    g = SEG7_GLYPH_C;
            4'hD:    g = SEG7_GLYPH_D;
            4'hE:    g = SEG7_GLYPH_E;
            default: g = SEG7_GLYPH_F;
        endcase
        return g;
    endfunction

endpackage

// File: rtl/seg7_hex_glyph.sv
// rtl/seg7_hex_glyph.sv - combinational nibble to active-low segment decode
module seg7_hex_glyph
    import seg7_pkg::*;
(
    input  logic [3:0] i_nibble,
    output logic [6:0] o_seg
);

    assign o_seg = seg7_glyph(i_nibble);

endmodule

// File: rtl/seg7_scan_driver.sv
// rtl/seg7_scan_driver.sv - double-buffered N-digit multiplexed seven-segment driver
// Optional leading-zero blanking: define SEG7_LEADING_ZERO_BLANK_EN.
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS   = 4,
    parameter int REFRESH_DIV  = 100000,
    parameter int BLANK_CYCLES = 16
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic [4*NUM_DIGITS-1:0] i_value,
    input  logic [NUM_DIGITS-1:0]   i_dp,
    input  logic [NUM_DIGITS-1:0]   i_blank_mask,
    input  logic                    i_load,
    output logic [6:0]              o_seg,
    output logic                    o_dp_n,
    output logic [NUM_DIGITS-1:0]   o_an,
    output logic                    o_frame_start,
    output logic                    o_pending
);

    localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int IDX_W = $clog2(NUM_DIGITS);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

    logic [CNT_W-1:0]        r_cnt;
    logic [IDX_W-1:0]        r_idx;
    logic [4*NUM_DIGITS-1:0] r_pend_value, r_com_value;
    logic [NUM_DIGITS-1:0]   r_pend_dp, r_com_dp;
    logic [NUM_DIGITS-1:0]   r_pend_blank, r_com_blank;
    logic                    r_pending;

    logic                    w_boundary, w_commit, w_an_on, w_dark;
    logic [4*NUM_DIGITS-1:0] w_disp_value;
    logic [NUM_DIGITS-1:0]   w_disp_dp, w_disp_blank, w_lz_mask, w_an_onehot;
    logic [3:0]              w_nibble;
    logic                    w_dp_sel, w_blank_sel, w_lz_sel;
    logic [6:0]              w_glyph;

    assign w_boundary = (r_cnt == '0) && (r_idx == '0);
    assign w_commit   = w_boundary && r_pending;

    // Decode from the buffer being committed this cycle so frame_start shows the new value
    assign w_disp_value = w_commit ? r_pend_value : r_com_value;
    assign w_disp_dp    = w_commit ? r_pend_dp    : r_com_dp;
    assign w_disp_blank = w_commit ? r_pend_blank : r_com_blank;

`ifdef SEG7_LEADING_ZERO_BLANK_EN
    always_comb begin : lz_blank
        logic v_run;
        v_run     = 1'b1;
        w_lz_mask = '0;
        for (int d = NUM_DIGITS - 1; d > 0; d--) begin
            v_run        = v_run && (w_disp_value[d*4 +: 4] == 4'h0) && !w_disp_dp[d];
            w_lz_mask[d] = v_run;
        end
    end
`else
    assign w_lz_mask = '0;
`endif

    always_comb begin
        w_nibble    = '0;
        w_dp_sel    = 1'b0;
        w_blank_sel = 1'b0;
        w_lz_sel    = 1'b0;
        w_an_onehot = '0;
        for (int d = 0; d < NUM_DIGITS; d++) begin
            if (r_idx == IDX_W'(d)) begin
                w_nibble       = w_disp_value[d*4 +: 4];
                w_dp_sel       = w_disp_dp[d];
                w_blank_sel    = w_disp_blank[d];
                w_lz_sel       = w_lz_mask[d];
                w_an_onehot[d] = 1'b1;
            end
        end
    end

    assign w_dark = w_blank_sel | w_lz_sel;

    seg7_hex_glyph u_glyph (
        .i_nibble (w_nibble),
        .o_seg    (w_glyph)
    );

    generate
        if (BLANK_CYCLES == 0) begin : g_no_blank
            assign w_an_on = 1'b1;
        end else begin : g_blank
            assign w_an_on = (r_cnt >= CNT_W'(BLANK_CYCLES));
        end
    endgenerate

    assign o_pending = r_pending;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_cnt         <= '0;
            r_idx         <= '0;
            r_pend_value  <= '0;
            r_pend_dp     <= '0;
            r_pend_blank  <= '0;
            r_pending     <= 1'b0;
            r_com_value   <= '0;
            r_com_dp      <= '0;
            r_com_blank   <= '0;
            o_seg         <= SEG7_BLANK;
            o_dp_n        <= 1'b1;
            o_an          <= '1;
            o_frame_start <= 1'b0;
        end else begin
            if (r_cnt == CNT_LAST) begin
                r_cnt <= '0;
                r_idx <= (r_idx == IDX_LAST) ? '0 : r_idx + 1'b1;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end

            // A load on the boundary cycle refills pending after the old contents commit
            if (i_load) begin
                r_pend_value <= i_value;
                r_pend_dp    <= i_dp;
                r_pend_blank <= i_blank_mask;
                r_pending    <= 1'b1;
            end else if (w_commit) begin
                r_pending    <= 1'b0;
            end

            if (w_commit) begin
                r_com_value <= r_pend_value;
                r_com_dp    <= r_pend_dp;
                r_com_blank <= r_pend_blank;
            end

            o_seg         <= w_dark ? SEG7_BLANK : w_glyph;
            o_dp_n        <= w_dark | ~w_dp_sel;
            o_an          <= w_an_on ? ~w_an_onehot : '1;
            o_frame_start <= w_boundary;
        end
    end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// tb/tb_seg7_scan_driver.sv - directed self-checking bench for seg7_scan_driver (4 digits, 4-cycle slots)
module tb_seg7_scan_driver;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] value;
    logic [3:0]  dp;
    logic [3:0]  bm;
    logic        load;
    logic [6:0]  seg;
    logic        dp_n;
    logic [3:0]  an;
    logic        frame_start;
    logic        pending;

    int checks   = 0;
    int failures = 0;
    int k        = 0;

    // Expected glyphs packed {digit3, digit2, digit1, digit0}
    localparam logic [27:0] G_12AF = {7'h4F, 7'h12, 7'h08, 7'h38};
    localparam logic [27:0] G_2222 = {7'h12, 7'h12, 7'h12, 7'h12};
    localparam logic [27:0] G_1234 = {7'h7F, 7'h12, 7'h06, 7'h4C};
`ifdef SEG7_LEADING_ZERO_BLANK_EN
    localparam logic [27:0] G_VAL0 = {7'h7F, 7'h7F, 7'h7F, 7'h01};
    localparam logic [27:0] G_0050 = {7'h7F, 7'h7F, 7'h24, 7'h01};
`else
    localparam logic [27:0] G_VAL0 = {7'h01, 7'h01, 7'h01, 7'h01};
    localparam logic [27:0] G_0050 = {7'h01, 7'h01, 7'h24, 7'h01};
`endif

    always #5 clk = ~clk;

    seg7_scan_driver #(
        .NUM_DIGITS   (4),
        .REFRESH_DIV  (4),
        .BLANK_CYCLES (1)
    ) dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_value       (value),
        .i_dp          (dp),
        .i_blank_mask  (bm),
        .i_load        (load),
        .o_seg         (seg),
        .o_dp_n        (dp_n),
        .o_an          (an),
        .o_frame_start (frame_start),
        .o_pending     (pending)
    );

    task automatic tick;
        @(negedge clk);
        k++;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s cycle=%0d observed=%0h expected=%0h", tag, k, obs, exp);
        end
    endtask

    task automatic chk_reset;
        chk("rst_seg", 32'(seg), 32'h7F);
        chk("rst_dp_n", 32'(dp_n), 32'h1);
        chk("rst_an", 32'(an), 32'hF);
        chk("rst_frame_start", 32'(frame_start), 32'h0);
        chk("rst_pending", 32'(pending), 32'h0);
    endtask

    // Output seen after posedge number k reflects scan state s = k-1
    task automatic run_check(input int n, input logic [27:0] g, input logic [3:0] dpn, input logic pend);
        int s, c, slot;
        logic [3:0] an_exp;
        for (int i = 0; i < n; i++) begin
            tick;
            s    = k - 1;
            c    = s % 4;
            slot = (s / 4) % 4;
            an_exp = 4'hF;
            if (c != 0) an_exp[slot] = 1'b0;
            chk("an", 32'(an), 32'(an_exp));
            chk("seg", 32'(seg), 32'(g[slot*7 +: 7]));
            chk("dp_n", 32'(dp_n), 32'(dpn[slot]));
            chk("frame_start", 32'(frame_start), 32'((s % 16) == 0));
            chk("pending", 32'(pending), 32'(pend));
        end
    endtask

    task automatic to_boundary(input logic [27:0] g, input logic [3:0] dpn, input logic pend);
        while ((k % 16) != 0) run_check(1, g, dpn, pend);
    endtask

    task automatic do_load(input logic [15:0] v, input logic [3:0] d, input logic [3:0] b);
        value = v;
        dp    = d;
        bm    = b;
        load  = 1'b1;
        tick;
        load  = 1'b0;
        chk("pending_after_load", 32'(pending), 32'h1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; load = 1'b0; value = '0; dp = '0; bm = '0;
        tick;
        tick;
        chk_reset;

        rst = 1'b0;
        k   = 0;
        run_check(32, G_VAL0, 4'hF, 1'b0);

        // Mid-frame load only appears at the next frame_start
        run_check(5, G_VAL0, 4'hF, 1'b0);
        do_load(16'h12AF, 4'h0, 4'h0);
        to_boundary(G_VAL0, 4'hF, 1'b1);
        run_check(16, G_12AF, 4'hF, 1'b0);

        // Last write wins
        run_check(3, G_12AF, 4'hF, 1'b0);
        do_load(16'h1111, 4'h0, 4'h0);
        run_check(2, G_12AF, 4'hF, 1'b1);
        do_load(16'h2222, 4'h0, 4'h0);
        to_boundary(G_12AF, 4'hF, 1'b1);
        run_check(16, G_2222, 4'hF, 1'b0);

        // Decimal point on digit 2, digit 3 forced dark
        run_check(2, G_2222, 4'hF, 1'b0);
        do_load(16'h1234, 4'b0100, 4'b1000);
        to_boundary(G_2222, 4'hF, 1'b1);
        run_check(16, G_1234, 4'b1011, 1'b0);

        // Zero value then 0050 (leading-zero behaviour depends on build)
        run_check(1, G_1234, 4'b1011, 1'b0);
        do_load(16'h0000, 4'h0, 4'h0);
        to_boundary(G_1234, 4'b1011, 1'b1);
        run_check(16, G_VAL0, 4'hF, 1'b0);
        run_check(9, G_VAL0, 4'hF, 1'b0);
        do_load(16'h0050, 4'h0, 4'h0);
        to_boundary(G_VAL0, 4'hF, 1'b1);
        run_check(16, G_0050, 4'hF, 1'b0);

        // Reset mid-frame discards a pending load; load during reset is ignored
        run_check(6, G_0050, 4'hF, 1'b0);
        do_load(16'h8888, 4'hF, 4'h0);
        run_check(2, G_0050, 4'hF, 1'b1);
        rst   = 1'b1;
        value = 16'h9999;
        load  = 1'b1;
        tick;
        chk_reset;
        load = 1'b0;
        tick;
        chk("rst_load_pending", 32'(pending), 32'h0);
        rst = 1'b0;
        k   = 0;
        run_check(32, G_VAL0, 4'hF, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
